// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes an N-bit Johnson word to index/one-hot and
// tracks the expected step sequence, reporting lock and lock-breaking errors.
module johnson_decoder #(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 3,
    parameter int ALLOW_HOLD = 0,
    localparam int M         = 2 * N,
    localparam int W         = $clog2(2 * N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] q_in,
    output logic         valid,
    output logic         legal,
    output logic [W-1:0] idx,
    output logic [M-1:0] onehot,
    output logic         locked,
    output logic         step_err,
    output logic [7:0]   err_cnt
);

    localparam int RL = $clog2(LOCK_CNT + 1);
    localparam logic [M-1:0] ONE = M'(1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [RL-1:0] run_q, run_d;
    logic [W-1:0]  ref_q, ref_d;
    logic          valid_q, valid_d;
    logic          legal_q, legal_d;
    logic [W-1:0]  idx_q, idx_d;
    logic [M-1:0]  onehot_q, onehot_d;
    logic          locked_q, locked_d;
    logic          step_err_q, step_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          dec_legal;
    logic [W-1:0]  dec_idx;
    logic [W-1:0]  ref_next;
    logic          is_step;
    logic          is_hold;

    // Canonical word for index k: k leading ones for k <= N, then (k-N) leading zeros.
    function automatic logic [N-1:0] code_of(input int k);
        logic [N-1:0] c;
        c = '0;
        for (int j = 0; j < N; j++) begin
            if (k <= N) c[N-1-j] = (j < k);
            else        c[N-1-j] = (j >= k - N);
        end
        return c;
    endfunction

    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int k = 0; k < M; k++) begin
            if (q_in == code_of(k)) begin
                dec_legal = 1'b1;
                dec_idx   = W'(k);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        ref_d      = ref_q;
        valid_d    = 1'b0;
        legal_d    = legal_q;
        idx_d      = idx_q;
        onehot_d   = onehot_q;
        step_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        ref_next = (ref_q == W'(M - 1)) ? '0 : ref_q + 1'b1;
        is_step  = dec_legal && (dec_idx == ref_next);
        is_hold  = dec_legal && (dec_idx == ref_q) && (ALLOW_HOLD != 0);

        if (en) begin
            valid_d  = 1'b1;
            legal_d  = dec_legal;
            idx_d    = dec_idx;
            onehot_d = dec_legal ? (ONE << dec_idx) : '0;
            if (dec_legal) ref_d = dec_idx;

            case (state_q)
                SEARCH: begin
                    if (dec_legal) begin
                        state_d = TRACK;
                        run_d   = '0;
                    end
                end
                TRACK: begin
                    if (!dec_legal) begin
                        state_d = SEARCH;
                        run_d   = '0;
                    end else if (is_step) begin
                        run_d = run_q + 1'b1;
                        if (run_q == RL'(LOCK_CNT - 1)) state_d = LOCKED;
                    end else if (!is_hold) begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (!dec_legal) begin
                        state_d    = SEARCH;
                        run_d      = '0;
                        step_err_d = 1'b1;
                    end else if (!(is_step || is_hold)) begin
                        state_d    = TRACK;
                        run_d      = '0;
                        step_err_d = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        if (step_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEARCH;
            run_q      <= '0;
            ref_q      <= '0;
            valid_q    <= 1'b0;
            legal_q    <= 1'b0;
            idx_q      <= '0;
            onehot_q   <= '0;
            locked_q   <= 1'b0;
            step_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            ref_q      <= ref_d;
            valid_q    <= valid_d;
            legal_q    <= legal_d;
            idx_q      <= idx_d;
            onehot_q   <= onehot_d;
            locked_q   <= locked_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign valid    = valid_q;
    assign legal    = legal_q;
    assign idx      = idx_q;
    assign onehot   = onehot_q;
    assign locked   = locked_q;
    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: two instances (repeat = error, repeat = neutral)
// driven in parallel and compared every sample against a behavioural model.
module tb_johnson_decoder;

    localparam int N        = 4;
    localparam int M        = 2 * N;
    localparam int W        = 3;
    localparam int LOCK_CNT = 3;
    localparam int VW       = W + M + 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] q_in;

    logic         valid_a, legal_a, locked_a, step_err_a;
    logic [W-1:0] idx_a;
    logic [M-1:0] onehot_a;
    logic [7:0]   err_cnt_a;
    logic         valid_b, legal_b, locked_b, step_err_b;
    logic [W-1:0] idx_b;
    logic [M-1:0] onehot_b;
    logic [7:0]   err_cnt_b;

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ALLOW_HOLD(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in),
        .valid(valid_a), .legal(legal_a), .idx(idx_a), .onehot(onehot_a),
        .locked(locked_a), .step_err(step_err_a), .err_cnt(err_cnt_a)
    );

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ALLOW_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in),
        .valid(valid_b), .legal(legal_b), .idx(idx_b), .onehot(onehot_b),
        .locked(locked_b), .step_err(step_err_b), .err_cnt(err_cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cur_k  = 0;

    logic [N-1:0] codes [M];

    // Reference model state; index 0 = repeat is an error, 1 = repeat is neutral.
    int           e_mode [2];
    int           e_run  [2];
    int           e_ref  [2];
    int           e_errs [2];
    int           e_idx  [2];
    bit           e_valid[2];
    bit           e_legal[2];
    bit           e_lock [2];
    bit           e_step [2];
    logic [M-1:0] e_oh   [2];

    function automatic int find_k(input logic [N-1:0] q);
        for (int k = 0; k < M; k++) if (codes[k] == q) return k;
        return -1;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input int m);
        return {e_valid[m], e_legal[m], W'(e_idx[m]), e_oh[m], e_lock[m], e_step[m], 8'(e_errs[m])};
    endfunction

    function automatic logic [VW-1:0] obs(input int m);
        if (m == 0) return {valid_a, legal_a, idx_a, onehot_a, locked_a, step_err_a, err_cnt_a};
        return {valid_b, legal_b, idx_b, onehot_b, locked_b, step_err_b, err_cnt_b};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e_mode[m] = 0; e_run[m] = 0; e_ref[m] = 0; e_errs[m] = 0; e_idx[m] = 0;
            e_valid[m] = 0; e_legal[m] = 0; e_lock[m] = 0; e_step[m] = 0; e_oh[m] = '0;
        end
    endtask

    task automatic model_step(input bit e, input logic [N-1:0] q);
        int k;
        bit lg, good, hold;
        k  = find_k(q);
        lg = (k >= 0);
        for (int m = 0; m < 2; m++) begin
            e_step[m] = 0;
            if (!e) begin
                e_valid[m] = 0;
                continue;
            end
            e_valid[m] = 1;
            e_legal[m] = lg;
            e_idx[m]   = lg ? k : 0;
            e_oh[m]    = lg ? (M'(1) << k) : '0;
            if (e_mode[m] == 0) begin
                if (lg) begin e_mode[m] = 1; e_ref[m] = k; e_run[m] = 0; end
            end else begin
                good = lg && (k == (e_ref[m] + 1) % M);
                hold = lg && (k == e_ref[m]) && (m == 1);
                if (!lg) begin
                    if (e_mode[m] == 2) e_step[m] = 1;
                    e_mode[m] = 0; e_run[m] = 0;
                end else if (good) begin
                    if (e_mode[m] == 1) begin
                        e_run[m]++;
                        if (e_run[m] >= LOCK_CNT) e_mode[m] = 2;
                    end
                    e_ref[m] = k;
                end else if (!hold) begin
                    if (e_mode[m] == 2) e_step[m] = 1;
                    e_mode[m] = 1; e_run[m] = 0; e_ref[m] = k;
                end
            end
            if (e_step[m] && e_errs[m] < 255) e_errs[m]++;
            e_lock[m] = (e_mode[m] == 2);
        end
    endtask

    task automatic drive(input bit e, input logic [N-1:0] q);
        en   = e;
        q_in = q;
        @(posedge clk);
        model_step(e, q);
        @(negedge clk);
    endtask

    task automatic feed(input int k);
        cur_k = k;
        drive(1'b1, codes[k]);
    endtask

    task automatic drive_rst();
        rst  = 1'b1;
        en   = 1'($urandom);
        q_in = N'($urandom);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_rst();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== '0) begin
                fails++;
                $display("[TB] FAIL reset dut%0d: got %h expected %h", m, obs(m), {VW{1'b0}});
            end
        end
        drive(1'b0, 4'b1010);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_vec(m)) begin
                fails++;
                $display("[TB] FAIL reset_idle dut%0d: got %h expected %h", m, obs(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_lock_acquisition();
        int ks[4] = '{7, 0, 1, 2};
        for (int i = 0; i < 4; i++) begin
            feed(ks[i]);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL lock_acq dut%0d step %0d: got %h expected %h", m, i, obs(m), exp_vec(m));
                end
            end
        end
        checks++;
        if (locked_a !== 1'b1 || idx_a !== 3'd2 || onehot_a !== 8'h04) begin
            fails++;
            $display("[TB] FAIL lock_acq_final: got locked=%b idx=%0d onehot=%h expected locked=1 idx=2 onehot=04",
                     locked_a, idx_a, onehot_a);
        end
    endtask

    task automatic test_full_wrap();
        int ks[6] = '{3, 4, 5, 6, 7, 0};
        for (int i = 0; i < 6; i++) begin
            feed(ks[i]);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL full_wrap dut%0d step %0d: got %h expected %h", m, i, obs(m), exp_vec(m));
                end
            end
        end
        checks++;
        if (err_cnt_a !== 8'd0 || locked_a !== 1'b1) begin
            fails++;
            $display("[TB] FAIL full_wrap_final: got err_cnt=%0d locked=%b expected 0 and 1", err_cnt_a, locked_a);
        end
    endtask

    task automatic test_illegal_locked();
        drive(1'b1, 4'b0101);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_vec(m)) begin
                fails++;
                $display("[TB] FAIL illegal dut%0d: got %h expected %h", m, obs(m), exp_vec(m));
            end
        end
        checks++;
        if (step_err_a !== 1'b1 || err_cnt_a !== 8'd1 || locked_a !== 1'b0 || onehot_a !== 8'h00) begin
            fails++;
            $display("[TB] FAIL illegal_flags: got step_err=%b err_cnt=%0d locked=%b onehot=%h expected 1 1 0 00",
                     step_err_a, err_cnt_a, locked_a, onehot_a);
        end
        for (int k = 3; k <= 6; k++) begin
            feed(k);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL illegal_recover dut%0d k=%0d: got %h expected %h", m, k, obs(m), exp_vec(m));
                end
            end
            if (k == 3) begin
                checks++;
                if (step_err_a !== 1'b0 || locked_a !== 1'b0 || idx_a !== 3'd3) begin
                    fails++;
                    $display("[TB] FAIL illegal_pulse: got step_err=%b locked=%b idx=%0d expected 0 0 3",
                             step_err_a, locked_a, idx_a);
                end
            end
        end
    endtask

    task automatic test_skip_hold();
        int ks[17] = '{7, 0, 1, 2, 4, 5, 6, 7, 0, 1, 2, 2, 3, 4, 5, 6, 7};
        for (int i = 0; i < 17; i++) begin
            feed(ks[i]);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL skip_hold dut%0d step %0d: got %h expected %h", m, i, obs(m), exp_vec(m));
                end
            end
            if (i == 11) begin
                checks++;
                if (step_err_a !== 1'b1 || step_err_b !== 1'b0 || locked_b !== 1'b1) begin
                    fail_hold: begin
                        fails++;
                        $display("[TB] FAIL hold_policy: got err_a=%b err_b=%b locked_b=%b expected 1 0 1",
                                 step_err_a, step_err_b, locked_b);
                    end
                end
            end
        end
    endtask

    task automatic test_en_gaps();
        feed((cur_k + 1) % M);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, N'($urandom));
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL en_gap dut%0d cycle %0d: got %h expected %h", m, i, obs(m), exp_vec(m));
                end
            end
        end
        feed((cur_k + 1) % M);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== exp_vec(m)) begin
                fails++;
                $display("[TB] FAIL en_gap_resume dut%0d: got %h expected %h", m, obs(m), exp_vec(m));
            end
        end
        checks++;
        if (locked_a !== 1'b1 || step_err_a !== 1'b0) begin
            fails++;
            $display("[TB] FAIL en_gap_lock: got locked=%b step_err=%b expected 1 0", locked_a, step_err_a);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15)      drive(1'b0, N'($urandom));
            else if (r < 60) feed((cur_k + 1) % M);
            else if (r < 70) feed(cur_k);
            else if (r < 85) feed(int'($urandom_range(0, M - 1)));
            else             drive(1'b1, N'($urandom));
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL random dut%0d cycle %0d: got %h expected %h", m, i, obs(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 4'b0101);
            for (int k = 0; k < 4; k++) feed(k);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL saturation dut%0d round %0d: got %h expected %h", m, i, obs(m), exp_vec(m));
                end
            end
        end
        drive(1'b1, 4'b0101);
        checks++;
        if (err_cnt_a !== 8'd255 || err_cnt_b !== 8'd255) begin
            fails++;
            $display("[TB] FAIL saturation_final: got %0d/%0d expected 255/255", err_cnt_a, err_cnt_b);
        end
        for (int k = 0; k < 4; k++) feed(k);
    endtask

    task automatic test_back_to_back_reset();
        drive_rst();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m) !== '0) begin
                fails++;
                $display("[TB] FAIL midop_reset dut%0d: got %h expected %h", m, obs(m), {VW{1'b0}});
            end
        end
        for (int k = 4; k <= 7; k++) begin
            feed(k);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m) !== exp_vec(m)) begin
                    fails++;
                    $display("[TB] FAIL relock dut%0d k=%0d: got %h expected %h", m, k, obs(m), exp_vec(m));
                end
            end
            if (k == 6) begin
                checks++;
                if (locked_a !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL relock_early: got locked=%b expected 0", locked_a);
                end
            end
        end
        checks++;
        if (locked_a !== 1'b1 || err_cnt_a !== 8'd0) begin
            fails++;
            $display("[TB] FAIL relock_final: got locked=%b err_cnt=%0d expected 1 0", locked_a, err_cnt_a);
        end
    endtask

    initial begin
        for (int k = 0; k < M; k++) begin
            if (k <= N) codes[k] = N'(((1 << k) - 1) << (N - k));
            else        codes[k] = N'((1 << (M - k)) - 1);
        end
        rst  = 1'b1;
        en   = 1'b0;
        q_in = '0;
        model_reset();
        @(negedge clk);
        $display("[TB] starting johnson_decoder checks");
        test_reset();
        test_lock_acquisition();
        test_full_wrap();
        test_illegal_locked();
        test_skip_hold();
        test_en_gaps();
        test_random();
        test_saturation();
        test_back_to_back_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
